// File: rtl/hid_pkg.sv
// ---------------------------------------------------------------------------
// hid_pkg
//   Shared definitions for the HID endpoint on the IO-MCU byte link:
//   command codes, packet byte-index state encoding and the saturating
//   signed 8-bit adder used by the mouse accumulators.
// ---------------------------------------------------------------------------
package hid_pkg;

  // Command byte values sent by the MCU with data_in_start asserted.
  typedef enum logic [7:0] {
    CMD_STATUS = 8'h00,
    CMD_KEY    = 8'h01,
    CMD_MOUSE  = 8'h02,
    CMD_JOY    = 8'h03,
    CMD_DB9    = 8'h04,
    CMD_CLEAR  = 8'h05
  } hid_cmd_e;

  // Packet state: 0 = idle (no command latched), otherwise the index of the
  // next payload byte. Saturates at ST_MAX so long packets cannot wrap into
  // a low byte index and re-trigger byte-1/2/3 actions.
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_IDLE = '0;
  localparam logic [STATE_W-1:0] ST_B1   = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_B2   = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_B3   = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_MAX  = '1;

  // Signed 8-bit add clamped to [-128, +127]. Overflow is detected by the
  // 9-bit sum's top two bits disagreeing; the sign bit then says which rail.
  function automatic logic [7:0] sat_add8(input logic signed [7:0] a,
                                          input logic signed [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) begin
      return sum[8] ? 8'h80 : 8'h7f;
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/hid_quad_axis.sv
// ---------------------------------------------------------------------------
// hid_quad_axis
//   One mouse axis: a signed 8-bit saturating accumulator of MCU deltas that
//   is drained by one unit per tick, emitting one gray-code quadrature step
//   per unit drained.
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   tick_i         step enable (one cycle per quadrature period)
//   delta_valid_i  delta_i is a new delta to add this cycle
//   delta_i        signed 8-bit delta
//   phase_o        quadrature phases {p1, p0}
// ---------------------------------------------------------------------------
module hid_quad_axis
  import hid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       delta_valid_i,
  input  logic [7:0] delta_i,
  output logic [1:0] phase_o
);

  logic signed [7:0] acc_q, acc_d;
  logic signed [7:0] acc_stepped;
  logic [1:0]        phase_q, phase_d;

  always_comb begin
    acc_stepped = acc_q;
    phase_d     = phase_q;
    if (tick_i && (acc_q != '0)) begin
      if (acc_q[7]) begin
        acc_stepped = acc_q + 8'sd1;
        phase_d     = {phase_q[0], ~phase_q[1]};
      end else begin
        acc_stepped = acc_q - 8'sd1;
        phase_d     = {~phase_q[0], phase_q[1]};
      end
    end
    // Adding onto the already-stepped value gives sat(acc - sign(acc) + delta)
    // when a delta coincides with a tick, and sat(acc + delta) otherwise.
    acc_d = delta_valid_i ? sat_add8(acc_stepped, delta_i) : acc_stepped;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/hid_multi.sv
// ---------------------------------------------------------------------------
// hid_multi
//   HID endpoint on the IO-MCU byte link. Decodes MCU packets into the 8x8
//   C64 keyboard matrix, NUM_JOY joysticks and a quadrature mouse, and
//   reports local DB9 changes to the MCU by interrupt.
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   data_in_strobe/_start  byte valid / byte is a command byte
//   data_in, data_out      MCU byte in, registered reply byte out
//   db9_port, irq, iack    local DB9 state, change interrupt, acknowledge
//   joystick               joystick j on [8*j+7:8*j]
//   keyboard_matrix_out/in column drive / row sense, both active low
//   mouse_btns, mouse_x/y  button state, quadrature phases
//   mouse_strobe           one-cycle pulse on every mouse packet byte 3
// ---------------------------------------------------------------------------
module hid_multi
  import hid_pkg::*;
#(
  parameter int         NUM_JOY     = 2,
  parameter int         MOUSE_DIV_W = 14,
  parameter logic [7:0] VERSION     = 8'h5c
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in_strobe,
  input  logic                 data_in_start,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [5:0]           db9_port,
  output logic                 irq,
  input  logic                 iack,
  output logic [8*NUM_JOY-1:0] joystick,
  input  logic [7:0]           keyboard_matrix_out,
  output logic [7:0]           keyboard_matrix_in,
  output logic [1:0]           mouse_btns,
  output logic [1:0]           mouse_x,
  output logic [1:0]           mouse_y,
  output logic                 mouse_strobe
);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [7:0]             dev_q, dev_d;
  logic [7:0]             dout_q, dout_d;
  logic [7:0][7:0]        keys_q, keys_d;     // keys[column][row], 1 = released
  logic [7:0]             joy_q [NUM_JOY];
  logic [7:0]             joy_d [NUM_JOY];
  logic [1:0]             btns_q, btns_d;
  logic                   irq_q, irq_d;
  logic                   irq_en_q, irq_en_d;
  logic [5:0]             db9_q, db9_d;
  logic                   strobe_q, strobe_d;
  logic [MOUSE_DIV_W-1:0] div_q;
  logic                   tick;
  logic                   dx_valid, dy_valid;
  logic                   payload;

  assign tick    = (div_q == '0);
  assign payload = data_in_strobe && !data_in_start && (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dev_d    = dev_q;
    dout_d   = dout_q;
    keys_d   = keys_q;
    joy_d    = joy_q;
    btns_d   = btns_q;
    irq_d    = irq_q;
    irq_en_d = irq_en_q;
    db9_d    = db9_q;
    strobe_d = 1'b0;
    dx_valid = 1'b0;
    dy_valid = 1'b0;

    // DB9 change detect: one-shot until re-armed by a DB9 command.
    if (irq_en_q) begin
      db9_d = db9_port;
    end
    if (irq_en_q && (db9_port != db9_q)) begin
      irq_d    = 1'b1;
      irq_en_d = 1'b0;
    end else if (iack) begin
      irq_d = 1'b0;
    end

    if (data_in_strobe && data_in_start) begin
      cmd_d   = data_in;
      state_d = ST_B1;
    end else if (payload) begin
      if (state_q != ST_MAX) begin
        state_d = state_q + STATE_W'(1);
      end
      case (cmd_q)
        CMD_STATUS: begin
          if (state_q == ST_B1) dout_d = VERSION;
          else if (state_q == ST_B2) dout_d = 8'(NUM_JOY);
        end
        CMD_KEY: begin
          if (state_q == ST_B1) keys_d[data_in[2:0]][data_in[5:3]] = data_in[7];
        end
        CMD_MOUSE: begin
          if (state_q == ST_B1) btns_d = data_in[1:0];
          if (state_q == ST_B2) dx_valid = 1'b1;
          if (state_q == ST_B3) begin
            dy_valid = 1'b1;
            strobe_d = 1'b1;
          end
        end
        CMD_JOY: begin
          if (state_q == ST_B1) dev_d = data_in;
          if (state_q == ST_B2) begin
            // Out-of-range device indices match no channel and are dropped.
            for (int j = 0; j < NUM_JOY; j++) begin
              if (dev_q == 8'(j)) joy_d[j] = data_in;
            end
          end
        end
        CMD_DB9: begin
          dout_d = {2'b00, db9_port};
          if (state_q == ST_B1) begin
            // Arm with the current port value as the reference.
            irq_en_d = 1'b1;
            db9_d    = db9_port;
          end
        end
        CMD_CLEAR: begin
          if (state_q == ST_B1) begin
            keys_d = '1;
            for (int j = 0; j < NUM_JOY; j++) joy_d[j] = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      dev_q    <= '0;
      dout_q   <= '0;
      keys_q   <= '1;
      for (int j = 0; j < NUM_JOY; j++) joy_q[j] <= '0;
      btns_q   <= '0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      db9_q    <= '0;
      strobe_q <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      dev_q    <= dev_d;
      dout_q   <= dout_d;
      keys_q   <= keys_d;
      joy_q    <= joy_d;
      btns_q   <= btns_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      db9_q    <= db9_d;
      strobe_q <= strobe_d;
      div_q    <= div_q + MOUSE_DIV_W'(1);
    end
  end

  hid_quad_axis u_axis_x (
    .clk           (clk),
    .reset         (reset),
    .tick_i        (tick),
    .delta_valid_i (dx_valid),
    .delta_i       (data_in),
    .phase_o       (mouse_x)
  );

  hid_quad_axis u_axis_y (
    .clk           (clk),
    .reset         (reset),
    .tick_i        (tick),
    .delta_valid_i (dy_valid),
    .delta_i       (data_in),
    .phase_o       (mouse_y)
  );

  // Keyboard rows: a column only contributes while it is driven low.
  logic [7:0] col_term [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col
      assign col_term[gi] = keyboard_matrix_out[gi] ? 8'hff : keys_q[gi];
    end
    for (gi = 0; gi < NUM_JOY; gi++) begin : g_joy
      assign joystick[8*gi +: 8] = joy_q[gi];
    end
  endgenerate

  always_comb begin
    keyboard_matrix_in = 8'hff;
    for (int c = 0; c < 8; c++) keyboard_matrix_in = keyboard_matrix_in & col_term[c];
  end

  assign data_out     = dout_q;
  assign irq          = irq_q;
  assign mouse_btns   = btns_q;
  assign mouse_strobe = strobe_q;

endmodule

// File: tb/tb_hid_multi.sv
module tb_hid_multi;
  localparam int NJ  = 2;
  localparam int DW  = 4;
  localparam int PER = 16;   // 2**DW

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe, start;
  logic [7:0]  din, dout;
  logic [5:0]  db9;
  logic        irq, iack;
  logic [15:0] joystick;
  logic [7:0]  col, row;
  logic [1:0]  btns, mx, my;
  logic        mstb;

  always #5 clk = ~clk;

  hid_multi #(.NUM_JOY(NJ), .MOUSE_DIV_W(DW), .VERSION(8'h5c)) dut (
    .clk                 (clk),
    .reset               (reset),
    .data_in_strobe      (strobe),
    .data_in_start       (start),
    .data_in             (din),
    .data_out            (dout),
    .db9_port            (db9),
    .irq                 (irq),
    .iack                (iack),
    .joystick            (joystick),
    .keyboard_matrix_out (col),
    .keyboard_matrix_in  (row),
    .mouse_btns          (btns),
    .mouse_x             (mx),
    .mouse_y             (my),
    .mouse_strobe        (mstb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one byte for exactly one posedge; returns at the following negedge.
  task automatic byte_tx(input logic s, input logic [7:0] d);
    strobe = 1'b1;
    start  = s;
    din    = d;
    @(negedge clk);
    strobe = 1'b0;
    start  = 1'b0;
    $display("byte start=%0d data=%02h -> dout=%02h joy=%04h row=%02h irq=%0d", s, d, dout, joystick, row, irq);
  endtask

  function automatic logic [1:0] gray_up(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_dn(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Watch mouse_x for a bounded window, checking step count, direction and spacing.
  task automatic watch_x(input string name, input int exp_steps, input bit up);
    logic [1:0] prev;
    int steps, bad_seq, bad_gap, last;
    prev = mx; steps = 0; bad_seq = 0; bad_gap = 0; last = -1;
    for (int c = 0; c < exp_steps * PER + 3 * PER; c++) begin
      @(negedge clk);
      if (mx != prev) begin
        if (mx != (up ? gray_up(prev) : gray_dn(prev))) bad_seq++;
        if (last >= 0 && (c - last) != PER) bad_gap++;
        last = c;
        steps++;
        prev = mx;
      end
    end
    $display("mouse %s: steps=%0d seq_err=%0d gap_err=%0d", name, steps, bad_seq, bad_gap);
    chk({name, "_steps"}, steps, exp_steps);
    chk({name, "_seq"}, bad_seq, 0);
    chk({name, "_gap"}, bad_gap, 0);
  endtask

  typedef struct {
    logic        strb;
    logic        st;
    logic [7:0]  d;
    logic [7:0]  col;
    logic [7:0]  dout;
    logic [15:0] joy;
    logic [7:0]  row;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic strb, input logic st, input logic [7:0] d, input logic [7:0] c,
                     input logic [7:0] o, input logic [15:0] j, input logic [7:0] r);
    vec_t v;
    v.strb = strb; v.st = st; v.d = d; v.col = c; v.dout = o; v.joy = j; v.row = r;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; strobe = 1'b0; start = 1'b0; din = 8'h00;
    db9 = 6'h2a; iack = 1'b0; col = 8'h00;

    // --- reset state ---
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_joy", joystick, 16'h0000);
    chk("rst_row", row, 8'hff);
    chk("rst_irq", irq, 1'b0);
    chk("rst_mx", mx, 2'b00);
    chk("rst_my", my, 2'b00);
    chk("rst_btns", btns, 2'b00);
    chk("rst_mstb", mstb, 1'b0);
    col = 8'hff;

    // --- mouse: packets land on divider 0..7 right after reset release ---
    reset = 1'b0;
    byte_tx(1, 8'h02); byte_tx(0, 8'h00); byte_tx(0, 8'h7f); byte_tx(0, 8'h00);
    chk("mstb_pulse", mstb, 1'b1);
    byte_tx(1, 8'h02);
    chk("mstb_clear", mstb, 1'b0);
    byte_tx(0, 8'h01); byte_tx(0, 8'h10); byte_tx(0, 8'h00);
    chk("btns", btns, 2'b01);
    watch_x("x_sat", 127, 1'b1);
    chk("my_idle", my, 2'b00);
    byte_tx(1, 8'h02); byte_tx(0, 8'h01); byte_tx(0, 8'hfd); byte_tx(0, 8'h00);
    watch_x("x_neg", 3, 1'b0);

    // --- table-driven command vectors (db9 held at 2a) ---
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    add(1,1,8'h00,8'hff,8'h00,16'h0000,8'hff);   // CMD0
    add(1,0,8'h11,8'hff,8'h5c,16'h0000,8'hff);
    add(1,0,8'h22,8'hff,8'h02,16'h0000,8'hff);
    add(1,0,8'h33,8'hff,8'h02,16'h0000,8'hff);
    add(1,1,8'h01,8'hff,8'h02,16'h0000,8'hff);   // CMD1 press col2 row1
    add(1,0,8'h0a,8'hfb,8'h02,16'h0000,8'hfd);
    add(1,1,8'h01,8'hfb,8'h02,16'h0000,8'hfd);   // press col2 row3
    add(1,0,8'h1a,8'hfb,8'h02,16'h0000,8'hf5);
    add(1,0,8'h8a,8'hfb,8'h02,16'h0000,8'hf5);   // byte2 of CMD1: no effect
    add(1,1,8'h01,8'hfb,8'h02,16'h0000,8'hf5);   // release col2 row1
    add(1,0,8'h8a,8'hfb,8'h02,16'h0000,8'hf7);
    add(1,1,8'h01,8'hfb,8'h02,16'h0000,8'hf7);   // press col5 row0
    add(1,0,8'h05,8'hdf,8'h02,16'h0000,8'hfe);
    add(0,0,8'h00,8'hdb,8'h02,16'h0000,8'hf6);   // two columns driven
    add(0,0,8'h00,8'hff,8'h02,16'h0000,8'hff);   // no column driven
    add(1,1,8'h03,8'hff,8'h02,16'h0000,8'hff);   // CMD3 dev1 = 55
    add(1,0,8'h01,8'hff,8'h02,16'h0000,8'hff);
    add(1,0,8'h55,8'hff,8'h02,16'h5500,8'hff);
    add(1,1,8'h03,8'hff,8'h02,16'h5500,8'hff);   // dev5 out of range
    add(1,0,8'h05,8'hff,8'h02,16'h5500,8'hff);
    add(1,0,8'haa,8'hff,8'h02,16'h5500,8'hff);
    add(1,1,8'h03,8'hff,8'h02,16'h5500,8'hff);   // dev0 = 3c
    add(1,0,8'h00,8'hff,8'h02,16'h5500,8'hff);
    add(1,0,8'h3c,8'hff,8'h02,16'h553c,8'hff);
    add(1,0,8'h77,8'hff,8'h02,16'h553c,8'hff);   // byte3 of CMD3: no effect
    add(1,1,8'h07,8'hff,8'h02,16'h553c,8'hff);   // unknown command
    add(1,0,8'h99,8'hff,8'h02,16'h553c,8'hff);
    add(1,1,8'h04,8'hff,8'h02,16'h553c,8'hff);   // CMD4
    add(1,0,8'h00,8'hff,8'h2a,16'h553c,8'hff);
    add(1,0,8'h00,8'hff,8'h2a,16'h553c,8'hff);
    add(1,1,8'h05,8'hdb,8'h2a,16'h553c,8'hf6);   // CMD5 clear
    add(1,0,8'h00,8'hdb,8'h2a,16'h0000,8'hff);
    for (int i = 0; i < tbl.size(); i++) begin
      col = tbl[i].col;
      if (tbl[i].strb) byte_tx(tbl[i].st, tbl[i].d);
      else @(negedge clk);
      chk($sformatf("v%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("v%0d_joy", i), joystick, tbl[i].joy);
      chk($sformatf("v%0d_row", i), row, tbl[i].row);
    end
    col = 8'hff;

    // --- IRQ (armed by the CMD4 in the table) ---
    chk("irq_idle", irq, 1'b0);
    db9 = 6'h2b;
    for (int i = 0; i < 2 && !irq; i++) @(negedge clk);
    chk("irq_set", irq, 1'b1);
    iack = 1'b1; @(negedge clk); iack = 1'b0;
    chk("irq_ack", irq, 1'b0);
    db9 = 6'h2a; repeat (3) @(negedge clk);
    chk("irq_oneshot", irq, 1'b0);
    byte_tx(1, 8'h04); byte_tx(0, 8'h00);
    chk("db9_dout", dout, 8'h2a);
    db9 = 6'h0a; iack = 1'b1; @(negedge clk); iack = 1'b0;
    chk("irq_set_wins", irq, 1'b1);
    iack = 1'b1; @(negedge clk); iack = 1'b0;
    chk("irq_ack2", irq, 1'b0);

    // --- reset mid-packet, then stray byte ---
    byte_tx(1, 8'h03); byte_tx(0, 8'h01);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("midrst_joy", joystick, 16'h0000);
    byte_tx(0, 8'hff);
    chk("stray_joy", joystick, 16'h0000);
    byte_tx(0, 8'h00);
    chk("stray_joy2", joystick, 16'h0000);

    // --- CMD5 after a key press ---
    col = 8'hfb;
    byte_tx(1, 8'h01); byte_tx(0, 8'h0a);
    chk("press_row", row, 8'hfd);
    byte_tx(1, 8'h05); byte_tx(0, 8'h00);
    chk("clear_row", row, 8'hff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
